phy_mode_ctrl: RTL



---
 rtl/i3c_pkg.sv | 46 ++++
 rtl/mode_switch_timer.sv | 36 +++
 rtl/phy_mode_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/i3c_pkg.sv
// Shared I3C/I2C PHY mode definitions: mode encoding, one-hot enable decode,
// and counter sizing helper.
// Latency: n/a (types and pure functions). Backpressure: n/a.
//
// Contents:
//   phy_mode_e  - PHY mux select encoding (controller/target, I2C/I3C)
//   mode_en_t   - the four mode-enable flags, one-hot for any legal mode
//   mode_decode - mode -> one-hot enable flags
//   cnt_width   - width needed to count up to max(a,b) inclusive
package i3c_pkg;

    typedef enum logic [1:0] {
        I2C_CTRL = 2'b00,
        I3C_CTRL = 2'b01,
        I2C_TGT  = 2'b10,
        I3C_TGT  = 2'b11
    } phy_mode_e;

    typedef struct packed {
        logic i3c_standby;
        logic i2c_standby;
        logic i3c_active;
        logic i2c_active;
    } mode_en_t;

    // Every 2-bit code maps to exactly one flag, so the decode can never
    // produce an all-zero or multi-hot result.
    function automatic mode_en_t mode_decode(input logic [1:0] mode);
        mode_en_t en;
        en = '0;
        case (mode)
            I2C_CTRL: en.i2c_active  = 1'b1;
            I3C_CTRL: en.i3c_active  = 1'b1;
            I2C_TGT:  en.i2c_standby = 1'b1;
            default:  en.i3c_standby = 1'b1;
        endcase
        return en;
    endfunction

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mode_switch_timer.sv
// Shared idle/settle timer: synchronous clear, saturating up-count, terminal compare.
// Latency: count updates one clock after clr_i/inc_i; tc_o is combinational on the count.
// Backpressure: none; the owning FSM decides when to clear or count.
//
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   clr_i         - clear the count to zero (wins over inc_i)
//   inc_i         - increment by one, holding at all-ones
//   term_i        - terminal value to compare against
//   tc_o          - current count equals term_i
module mode_switch_timer #(
    parameter int CntW = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    input  logic [CntW-1:0] term_i,
    output logic            tc_o
);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {CntW{1'b1}})) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign tc_o = (r_cnt == term_i);

endmodule

// File: rtl/phy_mode_ctrl.sv
// PHY mode controller: owns the PHY mux select and mode-enable flags and performs
// glitch-free, bus-idle-qualified switches between I2C/I3C controller/target modes.
// Latency: all outputs registered; a switch lands IdleCycles+2 clocks after the request
// with the bus idle throughout. Backpressure: none; a changed request is simply held
// pending until the bus has been idle long enough.
//
// Build option: define I3C_MODE_ABORT_FORCE_EN to let abort_i force a pending switch
// without waiting for bus idle; otherwise abort_i is ignored.
//
// Ports:
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   bus_enable_i        - bus enable level; low forces DISABLED
//   mode_req_i          - requested mode (00 i2c ctrl, 01 i3c ctrl, 10 i2c tgt, 11 i3c tgt)
//   bus_idle_i          - bus monitor idle indication
//   abort_i             - force a pending switch (only with I3C_MODE_ABORT_FORCE_EN)
//   mode_o              - PHY mux select
//   i2c/i3c_active/standby_en_o - one-hot decode of mode_o
//   phy_en_o            - PHY / controller-target FSM enable
//   busy_o              - switch in progress
//   switch_done_o       - one-cycle pulse when a switch completes
module phy_mode_ctrl
    import i3c_pkg::*;
#(
    parameter int         IdleCycles   = 16,
    parameter int         SettleCycles = 4,
    parameter logic [1:0] ResetMode    = 2'b11
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       bus_enable_i,
    input  logic [1:0] mode_req_i,
    input  logic       bus_idle_i,
    input  logic       abort_i,
    output logic [1:0] mode_o,
    output logic       i2c_active_en_o,
    output logic       i3c_active_en_o,
    output logic       i2c_standby_en_o,
    output logic       i3c_standby_en_o,
    output logic       phy_en_o,
    output logic       busy_o,
    output logic       switch_done_o
);

    localparam int CntW = cnt_width(IdleCycles, SettleCycles);

    // WAIT_IDLE expires on the idle cycle that would bring the count to
    // IdleCycles, so the compare value is one less.
    localparam logic [CntW-1:0] IdleTerm   = CntW'(IdleCycles - 1);
    // SETTLE leaves once the count reaches SettleCycles, which keeps the PHY
    // off through the mux write cycle plus the full settle window.
    localparam logic [CntW-1:0] SettleTerm = CntW'(SettleCycles);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_ACTIVE,
        ST_WAIT_IDLE,
        ST_SWITCH,
        ST_SETTLE
    } state_e;

    state_e     r_state;
    state_e     w_state_nxt;
    logic [1:0] r_mode;
    logic [1:0] w_mode_nxt;
    mode_en_t   r_en;
    logic       r_phy_en;
    logic       r_busy;
    logic       r_done;
    logic       w_phy_en_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;

    logic            w_cnt_clr;
    logic            w_cnt_inc;
    logic [CntW-1:0] w_term;
    logic            w_tc;
    logic            w_abort;

`ifdef I3C_MODE_ABORT_FORCE_EN
    assign w_abort = abort_i;
`else
    logic w_unused_abort;
    assign w_unused_abort = abort_i;
    assign w_abort        = 1'b0;
`endif

    // Terminal value depends only on the current state, kept outside the
    // FSM process so the timer compare does not loop back through it.
    assign w_term = (r_state == ST_WAIT_IDLE) ? IdleTerm : SettleTerm;

    mode_switch_timer #(
        .CntW (CntW)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_cnt_clr),
        .inc_i  (w_cnt_inc),
        .term_i (w_term),
        .tc_o   (w_tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_DISABLED;
            r_mode   <= ResetMode;
            r_en     <= mode_decode(ResetMode);
            r_phy_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_en     <= mode_decode(w_mode_nxt);
            r_phy_en <= w_phy_en_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_phy_en_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_DISABLED: begin
                // Enabling from cold needs no idle wait: nothing is driving the bus.
                if (bus_enable_i) begin
                    w_mode_nxt  = mode_req_i;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_ACTIVE: begin
                if (!bus_enable_i) begin
                    w_state_nxt = ST_DISABLED;
                end else if (mode_req_i != r_mode) begin
                    w_state_nxt = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                // Idle must be consecutive: any busy cycle restarts the count.
                w_cnt_inc = bus_idle_i;
                w_cnt_clr = !bus_idle_i;
                if (!bus_enable_i) begin
                    w_state_nxt = ST_DISABLED;
                end else if (w_abort) begin
                    w_state_nxt = ST_SWITCH;
                end else if (w_tc && bus_idle_i) begin
                    w_state_nxt = ST_SWITCH;
                end else if (mode_req_i == r_mode) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_SWITCH: begin
                // The PHY is already off this cycle, so the mux moves with
                // phy_en low both before and during the change.
                w_mode_nxt  = mode_req_i;
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_cnt_inc = 1'b1;
                if (!bus_enable_i) begin
                    w_state_nxt = ST_DISABLED;
                end else if (w_tc) begin
                    w_state_nxt = ST_ACTIVE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_DISABLED;
            end
        endcase

        // The shared counter starts from zero in whichever state comes next.
        if (w_state_nxt != r_state) begin
            w_cnt_clr = 1'b1;
        end

        w_phy_en_nxt = (w_state_nxt == ST_ACTIVE) || (w_state_nxt == ST_WAIT_IDLE);
        w_busy_nxt   = (w_state_nxt == ST_WAIT_IDLE) || (w_state_nxt == ST_SWITCH) ||
                       (w_state_nxt == ST_SETTLE);
    end

    assign mode_o           = r_mode;
    assign i2c_active_en_o  = r_en.i2c_active;
    assign i3c_active_en_o  = r_en.i3c_active;
    assign i2c_standby_en_o = r_en.i2c_standby;
    assign i3c_standby_en_o = r_en.i3c_standby;
    assign phy_en_o         = r_phy_en;
    assign busy_o           = r_busy;
    assign switch_done_o    = r_done;

endmodule
